fetch_controller: RTL and testbench

- Sequences the instruction-fetch stage: owns the architectural fetch PC and drives the instruction-memory request/grant/response handshake.
- Presents an 8-byte-aligned fetch line plus the current PC to the IF stage, which selects the 32-bit word using pc[2].
- Handles downstream stalls, branch/exception redirects, discard of stale in-flight responses, and reuse of a fetched line for both of its words.

---
 rtl/fetch_controller_pkg.sv | 37 +++
 rtl/fetch_controller_perf.sv | 22 ++
 rtl/fetch_controller.sv | 138 +++++++++++++
 tb/tb_fetch_controller.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg
//   Shared constants and types for the instruction-fetch controller.
//   The `define constants are the shared header:
//     `ADDR_LEN, `INSN_LEN  - address and instruction widths
//     `FETCH_ST_*           - FSM state encoding
//   The package wraps these values in an enum and provides PC helper functions.
//   Optional feature macro used by this block: FETCH_PERF_EN.
`ifndef FETCH_CONTROLLER_DEFS
`define FETCH_CONTROLLER_DEFS
`define ADDR_LEN        32
`define INSN_LEN        32
`define FETCH_ST_IDLE   2'd0
`define FETCH_ST_REQ    2'd1
`define FETCH_ST_WAIT   2'd2
`define FETCH_ST_OUT    2'd3
`endif

package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `FETCH_ST_IDLE,
        ST_REQ  = `FETCH_ST_REQ,
        ST_WAIT = `FETCH_ST_WAIT,
        ST_OUT  = `FETCH_ST_OUT
    } fetch_state_e;

    // Instruction-word alignment: the low two bits of a PC are always zero.
    function automatic logic [`ADDR_LEN-1:0] word_align(input logic [`ADDR_LEN-1:0] pc);
        return pc & ~`ADDR_LEN'(3);
    endfunction

    // Address of the 8-byte fetch line that contains pc.
    function automatic logic [`ADDR_LEN-1:0] line_addr(input logic [`ADDR_LEN-1:0] pc);
        return {pc[`ADDR_LEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_controller_perf.sv
// fetch_perf_counter
//   A free-running 32-bit event counter. It wraps modulo 2^32 and is cleared by reset.
//   Ports:
//     clk_i    - clock
//     reset_i  - asynchronous active-low reset
//     inc_i    - count one event this cycle
//     cnt_o    - current count
module fetch_perf_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            cnt_o <= '0;
        else if (inc_i)
            cnt_o <= cnt_o + 32'd1;
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   This block is the instruction-fetch sequencer. It holds the architectural fetch PC
//   and runs the instruction-memory request/grant/response handshake. Only one
//   request can be outstanding at a time. It presents a 64-bit line together
//   with the current PC. The IF stage uses pc_o[2] to pick one word of that line.
//   Every output is decoded from registered state. No input has a combinational
//   path to any output.
//   Ports:
//     clk_i, reset_i       - clock and asynchronous active-low reset
//     imem_req_o/addr_o    - fetch request and 8-byte line address
//     imem_gnt_i           - request accepted
//     imem_rvalid_i/rdata_i- response (arrives at least one cycle after the grant)
//     stall_i              - the downstream stage cannot take the instruction
//     redirect_i/pc_i      - branch or exception redirect
//     valid_o, pc_o, idata_o - the presented instruction and its line
//     perf_*_cnt_o         - exist only when FETCH_PERF_EN is defined
//   Optional feature macro: FETCH_PERF_EN (adds the fetch and stall counters).
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [`ADDR_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic                   imem_req_o,
    output logic [`ADDR_LEN-1:0]   imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [2*`INSN_LEN-1:0] imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [`ADDR_LEN-1:0]   redirect_pc_i,
    output logic                   valid_o,
    output logic [`ADDR_LEN-1:0]   pc_o,
    output logic [2*`INSN_LEN-1:0] idata_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt_o,
    output logic [31:0]            perf_stall_cnt_o
`endif
);

    fetch_state_e           state;
    logic [`ADDR_LEN-1:0]   pc_q;
    logic [2*`INSN_LEN-1:0] line_q;
    // drop_q is set when the response for the outstanding request belongs to a
    // path that a redirect has already abandoned.
    logic                   drop_q;

    logic [`ADDR_LEN-1:0]   target_pc;
    assign target_pc = word_align(redirect_pc_i);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state  <= ST_IDLE;
            pc_q   <= RESET_PC;
            line_q <= '0;
            drop_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (redirect_i)
                        pc_q <= target_pc;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        pc_q <= target_pc;
                        // The memory already holds the old address. Its response must be thrown away.
                        if (imem_gnt_i) begin
                            state  <= ST_WAIT;
                            drop_q <= 1'b1;
                        end
                    end else if (imem_gnt_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q || redirect_i) begin
                            drop_q <= 1'b0;
                            state  <= ST_REQ;
                            if (redirect_i)
                                pc_q <= target_pc;
                        end else begin
                            line_q <= imem_rdata_i;
                            state  <= ST_OUT;
                        end
                    end else if (redirect_i) begin
                        drop_q <= 1'b1;
                        pc_q   <= target_pc;
                    end
                end
                ST_OUT: begin
                    if (redirect_i) begin
                        pc_q  <= target_pc;
                        state <= ST_REQ;
                    end else if (!stall_i) begin
                        pc_q <= pc_q + `ADDR_LEN'(4);
                        // The low word leads into the high word of the same line,
                        // so line_q is reused. The high word needs a new line.
                        if (pc_q[2])
                            state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o  = (state == ST_REQ);
    assign imem_addr_o = line_addr(pc_q);
    assign valid_o     = (state == ST_OUT);
    assign pc_o        = pc_q;
    assign idata_o     = line_q;

`ifdef FETCH_PERF_EN
    logic consume_evt;
    logic stall_evt;
    assign consume_evt = (state == ST_OUT) && !stall_i && !redirect_i;
    assign stall_evt   = (state == ST_OUT) && stall_i;

    fetch_perf_counter u_fetch_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (consume_evt),
        .cnt_o   (perf_fetch_cnt_o)
    );

    fetch_perf_counter u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stall_evt),
        .cnt_o   (perf_stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Directed scenarios followed by a randomized run. A transaction-level
//   reference model predicts the consumed PC stream, the line contents and the
//   request addresses.
module tb_fetch_controller;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [63:0] imem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [63:0] idata_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_controller #(.RESET_PC(RPC)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .idata_o       (idata_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a distinct value for every line address.
    function automatic logic [63:0] mem_line(input logic [31:0] a);
        logic [31:0] la;
        la = a & ~32'h7;
        return {la ^ 32'hA5A5_5A5A, ~la + 32'h0000_1357};
    endfunction

    // One clock: inputs driven at a negedge take effect at the next posedge.
    // Outputs are sampled at the negedge that follows.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== RPC || idata_o !== 64'd0) begin
            $display("FAIL reset_state: req=%b valid=%b pc=%h idata=%h, want 0 0 %h 0",
                     imem_req_o, valid_o, pc_o, idata_o, RPC);
            n_fail++;
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin
            $display("FAIL reset_perf: fetch=%0d stall=%0d, want 0 0", perf_fetch_cnt_o, perf_stall_cnt_o);
            n_fail++;
        end
`endif
    endtask

    task automatic test_first_fetch();
        reset_i = 1'b1;
        tick();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            $display("FAIL first_req: req=%b addr=%h, want 1 00000100", imem_req_o, imem_addr_o);
            n_fail++;
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            $display("FAIL first_wait: req=%b valid=%b, want 0 0", imem_req_o, valid_o);
            n_fail++;
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(32'h100);
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || idata_o !== mem_line(32'h100)) begin
            $display("FAIL first_out: valid=%b pc=%h idata=%h, want 1 00000100 %h",
                     valid_o, pc_o, idata_o, mem_line(32'h100));
            n_fail++;
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h104 || idata_o !== mem_line(32'h100) || imem_req_o !== 1'b0) begin
            $display("FAIL line_reuse: valid=%b pc=%h idata=%h req=%b, want 1 00000104 %h 0",
                     valid_o, pc_o, idata_o, imem_req_o, mem_line(32'h100));
            n_fail++;
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h104 || idata_o !== mem_line(32'h100) || imem_req_o !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h req=%b, want 1 00000104 0",
                         i, valid_o, pc_o, imem_req_o);
                n_fail++;
            end
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_stall_cnt_o !== 32'd5) begin
            $display("FAIL perf_stall: got %0d want 5", perf_stall_cnt_o);
            n_fail++;
        end
`endif
        stall_i = 1'b0;
        tick();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h108 || valid_o !== 1'b0) begin
            $display("FAIL next_line_req: req=%b addr=%h valid=%b, want 1 00000108 0",
                     imem_req_o, imem_addr_o, valid_o);
            n_fail++;
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt_o !== 32'd2) begin
            $display("FAIL perf_fetch: got %0d want 2", perf_fetch_cnt_o);
            n_fail++;
        end
`endif
    endtask

    task automatic test_redirect_wait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h2002;
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
            end
            n_checks++;
            if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
                $display("FAIL redir_wait[%0d]: valid=%b req=%b, want 0 0", i, valid_o, imem_req_o);
                n_fail++;
            end
            tick();
        end
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000 || valid_o !== 1'b0) begin
            $display("FAIL redir_rereq: req=%b addr=%h valid=%b, want 1 00002000 0",
                     imem_req_o, imem_addr_o, valid_o);
            n_fail++;
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(32'h2000);
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h2000 || idata_o !== mem_line(32'h2000)) begin
            $display("FAIL redir_out: valid=%b pc=%h idata=%h, want 1 00002000 %h",
                     valid_o, pc_o, idata_o, mem_line(32'h2000));
            n_fail++;
        end
    endtask

    task automatic test_gnt_redirect();
        tick();
        tick();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2008) begin
            $display("FAIL gr_req: req=%b addr=%h, want 1 00002008", imem_req_o, imem_addr_o);
            n_fail++;
        end
        imem_gnt_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(32'h2008);
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || valid_o !== 1'b0) begin
            $display("FAIL gr_rereq: req=%b addr=%h valid=%b, want 1 00000040 0",
                     imem_req_o, imem_addr_o, valid_o);
            n_fail++;
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(32'h40);
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h40 || idata_o !== mem_line(32'h40)) begin
            $display("FAIL gr_out: valid=%b pc=%h, want 1 00000040", valid_o, pc_o);
            n_fail++;
        end
    endtask

    task automatic test_gnt_wait();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h48) begin
                $display("FAIL gnt_hold[%0d]: req=%b addr=%h, want 1 00000048", i, imem_req_o, imem_addr_o);
                n_fail++;
            end
            tick();
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            $display("FAIL gnt_to_wait: req=%b valid=%b, want 0 0", imem_req_o, valid_o);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        reset_i = 1'b0;
        #1;
        n_checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== RPC || idata_o !== 64'd0) begin
            $display("FAIL async_reset: req=%b valid=%b pc=%h idata=%h, want 0 0 %h 0",
                     imem_req_o, valid_o, pc_o, idata_o, RPC);
            n_fail++;
        end
        tick();
        reset_i       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(32'h48);
        tick();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== RPC || valid_o !== 1'b0) begin
                $display("FAIL late_rvalid[%0d]: req=%b addr=%h valid=%b, want 1 %h 0",
                         i, imem_req_o, imem_addr_o, valid_o, RPC);
                n_fail++;
            end
            tick();
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_line(RPC);
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== RPC || idata_o !== mem_line(RPC)) begin
            $display("FAIL restart_out: valid=%b pc=%h, want 1 %h", valid_o, pc_o, RPC);
            n_fail++;
        end
    endtask

    // Randomized run. The model tracks which PC the next consumed instruction
    // must have and the line address each accepted request must carry.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] paddr;
        logic [31:0] prev_addr;
        bit          pend;
        bit          prev_hold;
        int          cnt;
        int          consumed;
        int          stalls;
        int          bad;

        reset_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        tick();
        reset_i   = 1'b1;
        exp_pc    = RPC;
        pend      = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        cnt       = 0;
        paddr     = '0;
        consumed  = 0;
        stalls    = 0;
        bad       = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_hold) begin
                n_checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
                    if (bad < 10) $display("FAIL rnd_req_hold@%0d: req=%b addr=%h, want 1 %h",
                                           cyc, imem_req_o, imem_addr_o, prev_addr);
                    bad++;
                    n_fail++;
                end
            end

            imem_rvalid_i = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_line(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_gnt_i    = imem_req_o && ($urandom_range(1, 0) == 1);
            stall_i       = ($urandom_range(9, 0) < 3);
            redirect_i    = ($urandom_range(19, 0) == 0);
            redirect_pc_i = $urandom;

            if (valid_o && !stall_i && !redirect_i) begin
                n_checks++;
                if (pc_o !== exp_pc || idata_o !== mem_line(exp_pc)) begin
                    if (bad < 10) $display("FAIL rnd_consume@%0d: pc=%h idata=%h, want %h %h",
                                           cyc, pc_o, idata_o, exp_pc, mem_line(exp_pc));
                    bad++;
                    n_fail++;
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (valid_o && stall_i)
                stalls++;
            if (imem_req_o && imem_gnt_i) begin
                if (!redirect_i) begin
                    n_checks++;
                    if (imem_addr_o !== (exp_pc & ~32'h7)) begin
                        if (bad < 10) $display("FAIL rnd_req_addr@%0d: addr=%h, want %h",
                                               cyc, imem_addr_o, exp_pc & ~32'h7);
                        bad++;
                        n_fail++;
                    end
                end
                pend  = 1'b1;
                cnt   = $urandom_range(3, 0);
                paddr = imem_addr_o;
            end
            if (redirect_i)
                exp_pc = redirect_pc_i & ~32'h3;
            prev_hold = imem_req_o && !imem_gnt_i && !redirect_i;
            prev_addr = imem_addr_o;
            tick();
        end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;

        n_checks++;
        if (consumed < 50) begin
            $display("FAIL rnd_progress: consumed=%0d, want at least 50", consumed);
            n_fail++;
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt_o !== 32'(consumed) || perf_stall_cnt_o !== 32'(stalls)) begin
            $display("FAIL rnd_perf: fetch=%0d stall=%0d, want %0d %0d",
                     perf_fetch_cnt_o, perf_stall_cnt_o, consumed, stalls);
            n_fail++;
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_gnt_redirect();
        test_gnt_wait();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
